serial_addsub_ctrl: RTL and testbench

SERIAL_ADDSUB_CTRL -- requirements
Module: serial_addsub_ctrl

---
 rtl/serial_addsub_ctrl.sv | 137 +++++++++++++
 tb/tb_serial_addsub_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/serial_addsub_ctrl.sv
// serial_addsub_ctrl: bit-serial adder/subtractor, LSB first, one NAND full adder.
// Ports: clk, rst_n (sync, active-low), start, sub, a, b -> busy, done, result, cout, overflow.
// Optional macro OVERFLOW_DETECT_EN builds the signed-overflow flag; otherwise overflow is 0.
module serial_addsub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] res;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             sub_q;
    logic             cout_q;
    logic             last;

    // Full adder: two NAND half adders and a NAND carry merge
    logic fa_x;
    logic fa_y;
    logic n1;
    logic hs1;
    logic n2;
    logic fa_s;
    logic fa_c;

    assign fa_x = sh_a[0];
    assign fa_y = sh_b[0] ^ sub_q;
    assign n1   = ~(fa_x & fa_y);
    assign hs1  = ~(~(fa_x & n1) & ~(fa_y & n1));
    assign n2   = ~(hs1 & carry);
    assign fa_s = ~(~(hs1 & n2) & ~(carry & n2));
    assign fa_c = ~(n1 & n2);

    assign last = (cnt == LAST);

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nx = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            sh_a   <= '0;
            sh_b   <= '0;
            res    <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            sub_q  <= 1'b0;
            cout_q <= 1'b0;
        end else begin
            state <= state_nx;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        sh_a  <= a;
                        sh_b  <= b;
                        carry <= sub;
                        sub_q <= sub;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    sh_a  <= sh_a >> 1;
                    sh_b  <= sh_b >> 1;
                    res   <= {fa_s, res[WIDTH-1:1]};
                    carry <= fa_c;
                    cnt   <= cnt + CW'(1);
                    if (last) cout_q <= fa_c;
                end
                default: ;
            endcase
        end
    end

    assign result = res;
    assign cout   = cout_q;

`ifdef OVERFLOW_DETECT_EN
    logic msb_c;
    logic ovf_q;

    // msb_c captures the carry produced by bit WIDTH-2, i.e. the carry into the MSB
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            msb_c <= 1'b0;
            ovf_q <= 1'b0;
        end else if (state == RUN) begin
            if (cnt == CW'(WIDTH - 2)) msb_c <= fa_c;
            if (last) ovf_q <= msb_c ^ fa_c;
        end
    end

    assign overflow = ovf_q;
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// tb_serial_addsub_ctrl: directed and random checks of serial_addsub_ctrl (WIDTH=8)
// against an arithmetic reference model.
module tb_serial_addsub_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         overflow;

    int errors = 0;
    int checks = 0;

    serial_addsub_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .sub      (sub),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands
    task automatic model(input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic ts, output logic [W-1:0] er,
                         output logic ec, output logic eo);
        int ua;
        int ub;
        int sa;
        int sb;
        int sr;
        ua = int'(ta);
        ub = int'(tb);
        sa = int'($signed(ta));
        sb = int'($signed(tb));
        if (ts) begin
            er = W'(ua - ub);
            ec = (ua >= ub);
            sr = sa - sb;
        end else begin
            er = W'(ua + ub);
            ec = (ua + ub) > 255;
            sr = sa + sb;
        end
`ifdef OVERFLOW_DETECT_EN
        eo = (sr > 127) || (sr < -128);
`else
        eo = 1'b0;
        if (sr > 1000) eo = 1'b1;
`endif
    endtask

    // One operation; disturb = RUN cycle at which a stray start is raised (-1: none).
    // Inputs are scrambled during RUN, and start is held through the DONE cycle.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic ts, input int disturb);
        logic [W-1:0] er;
        logic         ec;
        logic         eo;
        model(ta, tb, ts, er, ec, eo);
        a     = ta;
        b     = tb;
        sub   = ts;
        start = 1'b1;
        tick();
        for (int i = 1; i <= W; i++) begin
            check("busy_run", busy, 1);
            check("done_run", done, 0);
            a     = W'($urandom);
            b     = W'($urandom);
            sub   = 1'($urandom);
            start = (i == disturb);
            tick();
        end
        check("done_pulse", done, 1);
        check("busy_done", busy, 0);
        check("result", result, er);
        check("cout", cout, ec);
        check("overflow", overflow, eo);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("done_low", done, 0);
        check("busy_idle", busy, 0);
        check("result_hold", result, er);
        check("cout_hold", cout, ec);
        check("ovf_hold", overflow, eo);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b1;
        sub   = 1'b0;
        a     = 8'hAA;
        b     = 8'h55;
        tick();
        tick();
        rst_n = 1'b1;
        start = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_cout", cout, 0);
        check("rst_ovf", overflow, 0);
        tick();
        check("rst_start_ign", busy, 0);

        run_op(8'h3C, 8'h15, 1'b0, -1);
        run_op(8'hFF, 8'h01, 1'b0, -1);
        run_op(8'h7F, 8'h01, 1'b0, -1);
        run_op(8'h10, 8'h20, 1'b1, -1);
        run_op(8'h80, 8'h01, 1'b1, -1);
        run_op(8'h5A, 8'hC3, 1'b0, 3);

        // Reset mid-RUN with a coincident start
        a     = 8'h44;
        b     = 8'h33;
        sub   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst_n = 1'b0;
        start = 1'b1;
        tick();
        rst_n = 1'b1;
        start = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_result", result, 0);
        check("abort_cout", cout, 0);
        check("abort_ovf", overflow, 0);
        for (int i = 0; i < W + 2; i++) begin
            check("abort_no_done", done, 0);
            check("abort_no_busy", busy, 0);
            tick();
        end
        run_op(8'h01, 8'h02, 1'b0, -1);

        for (int n = 0; n < 25; n++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom),
                   int'($urandom_range(0, W + 2)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
